// File: rtl/pmt_pkg.sv
// Shared types and default constants for the permit arbiter.
// Holds the FSM state encoding and default parameter values.
package pmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } pmt_state_t;

    localparam int PMT_N_CH_DEF = 4;
    localparam int PMT_TO_W_DEF = 8;
    localparam int PMT_GAP_DEF  = 2;

endpackage

// File: rtl/pmt_sync.sv
// Fire-line synchronizer: two flops plus history flop, edge output.
// Ports: clk, rst (async low), i_async (raw fire), o_edge (either polarity).
module pmt_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_hist <= r_s2;
        end
    end

    assign o_edge = r_s2 ^ r_hist;

endmodule

// File: rtl/pmt_arbiter.sv
// Round-robin permit arbiter for click-controlled FIFO stages.
// Ports: clk, rst, en, req, fire, to_lim -> pmt, busy, grant_id, done, to_err, err_ch, spur_err.
module pmt_arbiter
    import pmt_pkg::*;
#(
    parameter int N_CH = PMT_N_CH_DEF,
    parameter int TO_W = PMT_TO_W_DEF,
    parameter int GAP  = PMT_GAP_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [N_CH-1:0]                req,
    input  logic [N_CH-1:0]                fire,
    input  logic [TO_W-1:0]                to_lim,
    output logic [N_CH-1:0]                pmt,
    output logic                           busy,
    output logic [$clog2(N_CH)-1:0]        grant_id,
    output logic                           done,
    output logic                           to_err,
    output logic [$clog2(N_CH)-1:0]        err_ch,
    output logic                           spur_err
);

    localparam int IW = $clog2(N_CH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [N_CH-1:0] w_edge;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        pmt_sync u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_async (fire[g]),
            .o_edge  (w_edge[g])
        );
    end

    pmt_state_t      r_state, w_state_nxt;
    logic [N_CH-1:0] r_pmt, w_pmt_nxt;
    logic            r_busy, w_busy_nxt;
    logic [IW-1:0]   r_gid, w_gid_nxt;
    logic [IW-1:0]   r_rr, w_rr_nxt;
    logic            r_done, w_done_nxt;
    logic            r_to_err, w_to_err_nxt;
    logic [IW-1:0]   r_err_ch, w_err_ch_nxt;
    logic            r_spur, w_spur_nxt;
    logic [TO_W-1:0] r_tcnt, w_tcnt_nxt;
    logic [GW-1:0]   r_gcnt, w_gcnt_nxt;

    logic            w_any;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic            w_spur_hit;
    logic            w_gnt_edge;
    logic            w_tmo;
    logic [TO_W:0]   w_tnext;

    // Downward scan so the last hit is the first requester at or above r_rr.
    always_comb begin
        w_any = 1'b0;
        w_win = r_rr;
        w_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_idx = IW'((int'(r_rr) + i) % N_CH);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Any edge except the live grantee's own is spurious.
    always_comb begin
        w_spur_hit = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_edge[k] &&
                !(r_state == ST_GRANT && r_gid == IW'(k)))
                w_spur_hit = 1'b1;
        end
    end

    assign w_gnt_edge = w_edge[r_gid];
    assign w_tnext    = {1'b0, r_tcnt} + 1'b1;
    assign w_tmo      = (to_lim != '0) &&
                        (w_tnext >= {1'b0, to_lim});

    always_comb begin
        w_state_nxt  = r_state;
        w_pmt_nxt    = r_pmt;
        w_busy_nxt   = r_busy;
        w_gid_nxt    = r_gid;
        w_rr_nxt     = r_rr;
        w_done_nxt   = 1'b0;
        w_to_err_nxt = r_to_err;
        w_err_ch_nxt = r_err_ch;
        w_spur_nxt   = r_spur | w_spur_hit;
        w_tcnt_nxt   = r_tcnt;
        w_gcnt_nxt   = r_gcnt;
        unique case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (en && w_any) begin
                    w_state_nxt       = ST_GRANT;
                    w_pmt_nxt         = '0;
                    w_pmt_nxt[w_win]  = 1'b1;
                    w_gid_nxt         = w_win;
                    w_busy_nxt        = 1'b1;
                    w_tcnt_nxt        = '0;
                    w_rr_nxt = (w_win == IW'(N_CH - 1)) ?
                               '0 : w_win + 1'b1;
                end
            end
            ST_GRANT: begin
                // Fire is tested first so it wins a tie with timeout.
                if (w_gnt_edge) begin
                    w_state_nxt = ST_GAP;
                    w_pmt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_gcnt_nxt  = '0;
                end else if (w_tmo) begin
                    w_state_nxt  = ST_GAP;
                    w_pmt_nxt    = '0;
                    w_to_err_nxt = 1'b1;
                    w_err_ch_nxt = r_gid;
                    w_gcnt_nxt   = '0;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gcnt == GW'(GAP - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_gcnt_nxt = r_gcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pmt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_pmt    <= '0;
            r_busy   <= 1'b0;
            r_gid    <= '0;
            r_rr     <= '0;
            r_done   <= 1'b0;
            r_to_err <= 1'b0;
            r_err_ch <= '0;
            r_spur   <= 1'b0;
            r_tcnt   <= '0;
            r_gcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pmt    <= w_pmt_nxt;
            r_busy   <= w_busy_nxt;
            r_gid    <= w_gid_nxt;
            r_rr     <= w_rr_nxt;
            r_done   <= w_done_nxt;
            r_to_err <= w_to_err_nxt;
            r_err_ch <= w_err_ch_nxt;
            r_spur   <= w_spur_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_gcnt   <= w_gcnt_nxt;
        end
    end

    assign pmt      = r_pmt;
    assign busy     = r_busy;
    assign grant_id = r_gid;
    assign done     = r_done;
    assign to_err   = r_to_err;
    assign err_ch   = r_err_ch;
    assign spur_err = r_spur;

endmodule

// File: tb/tb_pmt_arbiter.sv
// Self-checking bench for pmt_arbiter with a round-robin reference model.
// Drives inputs and samples outputs on the falling clock edge.
module tb_pmt_arbiter;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int GP = 2;
    localparam int NIT = 40;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  fire;
    logic [TW-1:0] to_lim;
    logic [N-1:0]  pmt;
    logic          busy;
    logic [1:0]    grant_id;
    logic          done;
    logic          to_err;
    logic [1:0]    err_ch;
    logic          spur_err;

    int errors = 0;
    int checks = 0;
    int m_rr = 0;
    logic       exp_to_err = 1'b0;
    logic [1:0] exp_err_ch = 2'd0;

    logic [3:0] dr [9] = '{4'hF, 4'hF, 4'hF, 4'hF,
                          4'h5, 4'h5, 4'hF, 4'h4, 4'h2};
    int dl [9] = '{0, 0, 0, 0, 0, 0, 0, 6, 5};
    int dk [9] = '{0, 2, 1, 0, 0, 1, 0, 3, 5};

    pmt_arbiter #(.N_CH(N), .TO_W(TW), .GAP(GP)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .fire     (fire),
        .to_lim   (to_lim),
        .pmt      (pmt),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done),
        .to_err   (to_err),
        .err_ch   (err_ch),
        .spur_err (spur_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int pick(logic [3:0] r, int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; req = '0;
        fire = '0; to_lim = '0;
        repeat (3) step();
        checks++; if (pmt !== 4'b0) begin errors++;
            $display("FAIL reset_pmt got=%b want=0000", pmt); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (grant_id !== 2'd0) begin errors++;
            $display("FAIL reset_gid got=%0d want=0", grant_id); end
        checks++; if (err_ch !== 2'd0) begin errors++;
            $display("FAIL reset_errch got=%0d want=0", err_ch); end
        checks++; if (to_err !== 1'b0) begin errors++;
            $display("FAIL reset_toerr got=%b want=0", to_err); end
        checks++; if (spur_err !== 1'b0) begin errors++;
            $display("FAIL reset_spur got=%b want=0", spur_err); end
        rst = 1'b1;
        m_rr = 0; exp_to_err = 1'b0; exp_err_ch = 2'd0;
        step();
    endtask

    task automatic test_grants();
        for (int it = 0; it < NIT; it++) begin
            logic [3:0] r;
            logic [3:0] ep;
            logic       fired;
            int lim, k, w, endc;
            bit dq, de;
            if (it < 9) begin
                r = dr[it]; lim = dl[it]; k = dk[it];
                dq = 0; de = 0;
            end else begin
                r   = 4'($urandom_range(1, 15));
                lim = ($urandom_range(0, 1) == 1) ?
                      int'($urandom_range(3, 10)) : 0;
                k   = int'($urandom_range(0, (lim != 0) ? lim : 5));
                dq  = ($urandom_range(0, 3) == 0);
                de  = ($urandom_range(0, 3) == 0);
            end
            to_lim = TW'(lim);
            req = r;
            en  = 1'b1;
            w  = pick(r, m_rr);
            ep = 4'(1 << w);
            m_rr = (w + 1) % N;
            fired = (lim == 0) || (k + 3 <= lim);
            endc  = fired ? k + 3 : lim;
            step();
            checks++; if (grant_id !== 2'(w)) begin errors++;
                $display("FAIL grant_id it=%0d got=%0d want=%0d",
                         it, grant_id, w); end
            checks++; if (busy !== 1'b1) begin errors++;
                $display("FAIL grant_busy it=%0d got=%b want=1",
                         it, busy); end
            for (int c = 0; c < endc; c++) begin
                checks++; if (pmt !== ep) begin errors++;
                    $display("FAIL grant_pmt it=%0d c=%0d got=%b want=%b",
                             it, c, pmt, ep); end
                checks++; if (done !== 1'b0) begin errors++;
                    $display("FAIL early_done it=%0d c=%0d got=%b want=0",
                             it, c, done); end
                if (c == 0 && dq) req = '0;
                if (c == 0 && de) en = 1'b0;
                if (c == k && fired) fire[w] = ~fire[w];
                step();
            end
            if (!fired) begin
                exp_to_err = 1'b1;
                exp_err_ch = 2'(w);
            end
            checks++; if (pmt !== 4'b0) begin errors++;
                $display("FAIL end_pmt it=%0d got=%b want=0000", it, pmt); end
            checks++; if (done !== fired) begin errors++;
                $display("FAIL end_done it=%0d got=%b want=%b",
                         it, done, fired); end
            checks++; if (to_err !== exp_to_err) begin errors++;
                $display("FAIL end_toerr it=%0d got=%b want=%b",
                         it, to_err, exp_to_err); end
            checks++; if (err_ch !== exp_err_ch) begin errors++;
                $display("FAIL end_errch it=%0d got=%0d want=%0d",
                         it, err_ch, exp_err_ch); end
            checks++; if (busy !== 1'b1) begin errors++;
                $display("FAIL gap_busy it=%0d got=%b want=1", it, busy); end
            checks++; if (spur_err !== 1'b0) begin errors++;
                $display("FAIL no_spur it=%0d got=%b want=0",
                         it, spur_err); end
            for (int g = 1; g < GP; g++) begin
                step();
                checks++; if (busy !== 1'b1 || pmt !== 4'b0 ||
                              done !== 1'b0) begin errors++;
                    $display("FAIL gap_hold it=%0d g=%0d got=%b/%b/%b want=1/0000/0",
                             it, g, busy, pmt, done); end
            end
            step();
            checks++; if (busy !== 1'b0 || pmt !== 4'b0) begin errors++;
                $display("FAIL idle_after_gap it=%0d got=%b/%b want=0/0000",
                         it, busy, pmt); end
            if (de) begin
                req = 4'hF;
                repeat (2) begin
                    step();
                    checks++; if (pmt !== 4'b0 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL en_low_hold it=%0d got=%b/%b want=0000/0",
                                 it, pmt, busy); end
                end
            end
        end
        en = 1'b1;
        req = '0;
        to_lim = '0;
    endtask

    task automatic test_spurious();
        req = 4'b0001; en = 1'b1;
        step();
        m_rr = 1;
        checks++; if (pmt !== 4'b0001) begin errors++;
            $display("FAIL spur_grant got=%b want=0001", pmt); end
        req = '0;
        fire[3] = ~fire[3];
        repeat (3) begin
            step();
            checks++; if (pmt !== 4'b0001) begin errors++;
                $display("FAIL spur_pmt_kept got=%b want=0001", pmt); end
        end
        checks++; if (spur_err !== 1'b1) begin errors++;
            $display("FAIL spur_flag got=%b want=1", spur_err); end
        fire[0] = ~fire[0];
        repeat (3) step();
        checks++; if (pmt !== 4'b0 || done !== 1'b1) begin errors++;
            $display("FAIL spur_end got=%b/%b want=0000/1", pmt, done); end
        repeat (GP) step();
        checks++; if (spur_err !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL spur_sticky got=%b/%b want=1/0", spur_err, busy); end
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0010; en = 1'b1;
        step();
        checks++; if (pmt !== 4'b0010) begin errors++;
            $display("FAIL rmid_grant got=%b want=0010", pmt); end
        #2;
        rst = 1'b0;
        fire = '0;
        #1;
        checks++; if (pmt !== 4'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rmid_async got=%b/%b want=0000/0", pmt, busy); end
        step();
        checks++; if (to_err !== 1'b0 || spur_err !== 1'b0 ||
                      err_ch !== 2'd0 || grant_id !== 2'd0) begin errors++;
            $display("FAIL rmid_flags got=%b/%b/%0d/%0d want=0/0/0/0",
                     to_err, spur_err, err_ch, grant_id); end
        rst = 1'b1;
        req = 4'hF;
        m_rr = 0; exp_to_err = 1'b0; exp_err_ch = 2'd0;
        step();
        checks++; if (pmt !== 4'b0001 || grant_id !== 2'd0) begin errors++;
            $display("FAIL rmid_restart got=%b/%0d want=0001/0",
                     pmt, grant_id); end
        req = '0;
        fire[0] = ~fire[0];
        repeat (3) step();
        checks++; if (done !== 1'b1 || pmt !== 4'b0) begin errors++;
            $display("FAIL rmid_done got=%b/%b want=1/0000", done, pmt); end
        repeat (GP) step();
    endtask

    task automatic test_reset_fire_high();
        rst = 1'b0;
        req = '0;
        fire = 4'b1000;
        step();
        rst = 1'b1;
        repeat (2) step();
        checks++; if (spur_err !== 1'b0) begin errors++;
            $display("FAIL rfh_early got=%b want=0", spur_err); end
        step();
        checks++; if (spur_err !== 1'b1 || pmt !== 4'b0) begin errors++;
            $display("FAIL rfh_edge got=%b/%b want=1/0000", spur_err, pmt); end
    endtask

    initial begin
        test_reset();
        test_grants();
        test_spurious();
        test_reset_mid_grant();
        test_reset_fire_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmt_arbiter.md
PMT_ARBITER -- requirements
Module: pmt_arbiter

Interface
REQ-001 Parameter N_CH, 4, number of permit-gated FIFO stages arbitrated.
REQ-002 Parameter TO_W, 8, timeout counter width.
REQ-003 Parameter GAP, 2, idle cycles with all permits low between grants.
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port rst  in  1  asynchronous active-low reset.
REQ-006 Port en  in  1  arbitration enable, synchronous.
REQ-007 Port req  in  N_CH  per-channel permit request level, synchronous.
REQ-008 Port fire  in  N_CH  per-stage fire (click) line, asynchronous; every transition is one completed transfer.
REQ-009 Port to_lim  in  TO_W  grant timeout in cycles; 0 disables timeout.
REQ-010 Port pmt  out  N_CH  permit to each stage; registered, one-hot or zero.
REQ-011 Port busy  out  1  high while a grant is outstanding or in gap.
REQ-012 Port grant_id  out  clog2(N_CH)  index of current/last grantee.
REQ-013 Port done  out  1  one-cycle pulse on fire-terminated grant.
REQ-014 Port to_err  out  1  sticky timeout flag.
REQ-015 Port err_ch  out  clog2(N_CH)  channel of most recent timeout.
REQ-016 Port spur_err  out  1  sticky flag, fire edge on non-granted channel.

Function
REQ-017 Each fire bit passes a 2-flop synchronizer plus history flop; edge = sync XOR history, either polarity.
REQ-018 FSM states IDLE, GRANT, GAP; one grant outstanding at most.
REQ-019 IDLE: en=1 and any req -> GRANT next edge; winner is first requesting channel searching upward (wrapping) from rr_ptr; pmt[winner], grant_id, busy set on same edge.
REQ-020 req sampled at edge E -> pmt high after E (latency 1).
REQ-021 rr_ptr <= winner+1 mod N_CH on entering GRANT; reset value 0.
REQ-022 GRANT: edge on granted channel -> GAP, pmt cleared, done=1 for one cycle.
REQ-023 Fire transition captured by first sync flop at E0 -> pmt low and done high after E0+2.
REQ-024 GRANT: timeout counter starts at 0 on entry, increments per cycle; reaching to_lim (nonzero) with no fire edge -> GAP, pmt cleared, to_err=1, err_ch=grant_id, no done.
REQ-025 Fire edge and timeout in same cycle: fire wins (done, no to_err).
REQ-026 req drop during GRANT does not revoke the permit; grant ends only by fire or timeout.
REQ-027 en low during GRANT: grant completes normally; FSM then holds IDLE until en=1.
REQ-028 GAP: all pmt low for exactly GAP cycles, then IDLE; busy high throughout GAP.
REQ-029 Fire edge on any channel other than the active grantee (including in IDLE/GAP) sets spur_err and is otherwise ignored.
REQ-030 to_err, spur_err clear only on reset.

Reset
REQ-031 rst low asynchronously forces state IDLE, pmt=0, busy=0, done=0, grant_id=0, err_ch=0, to_err=0, spur_err=0, rr_ptr=0, timeout counter=0.
REQ-032 Synchronizer and history flops reset to 0; a fire line already high at reset release reports one edge (flagged spur_err if not granted).
REQ-033 Reset mid-grant drops pmt immediately, without waiting for clk.

Structure
REQ-034 Package pmt_pkg holds the FSM state enum and default GAP/TO_W constants.
REQ-035 Sub-module pmt_sync (2-flop synchronizer + history flop + edge output), instantiated N_CH times.
REQ-036 Round-robin select, FSM, timeout counter and error flags reside in pmt_arbiter.

Verification
REQ-037 req=4'b0101, en=1, fire toggled on ch0 then ch2 -> pmt 0001 then 0100, each followed by GAP=2 zero cycles, done pulses twice, rr_ptr=3.
REQ-038 req=4'b1111 held, fire answered promptly -> grants cycle 0,1,2,3,0; no channel granted twice before others.
REQ-039 to_lim=5, ch1 granted, no fire -> pmt low after 5 GRANT cycles, to_err=1, err_ch=1, done stays 0.
REQ-040 ch2 granted, fire[2] edge detected in the to_lim cycle -> done=1, to_err=0.
REQ-041 fire[3] toggled while ch0 granted -> spur_err=1, pmt[0] unaffected.
REQ-042 rst asserted mid-GRANT between clock edges -> pmt=0 immediately; after release, to_err=0, grant restarts from ch0.
